uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver; the stage directly upstream of the RX word FIFO.
- Oversamples the serial line using the shared baud-tick strobe and assembles LSB-first frames into NB_WORD-bit words.
- Emits a one-cycle o_rx_done pulse per valid frame, which drives the FIFO write strobe; o_data drives the FIFO data input.

Parameters:
- NB_WORD, 8, data bits per frame and o_data width.
- N_TICK, 16, baud ticks per bit period; must be even and ≥4.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rx  input  1  asynchronous serial line; idle high.
- i_tick  input  1  baud oversample strobe, N_TICK per bit, one i_clk wide.
- o_data  output  NB_WORD  last valid received word.
- o_rx_done  output  1  one-cycle pulse: o_data is new this cycle.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 unless macro is defined).

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; all counters 0; shift register 0.
  - o_data=0; o_rx_done=0; o_frame_err=0; o_parity_err=0.
  - Both synchroniser flops set to 1.
- i_rx passes through a 2-flop synchroniser; rx_s lags i_rx by 2 clocks. All decisions use rx_s.
- tick_cnt (clog2(N_TICK) bits) and bit_cnt (clog2(NB_WORD) bits) advance only in cycles where i_tick=1. Cycles without a tick hold all state.
- IDLE: i_tick ignored; rx_s=0 -> START with tick_cnt=0.
- START: on a tick with tick_cnt==N_TICK/2-1:
  - rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1 -> glitch; return to IDLE with no output pulse.
  - Otherwise tick_cnt++.
- DATA: on a tick with tick_cnt==N_TICK-1:
  - Shift rx_s into the MSB of the shift register (LSB-first line order); tick_cnt=0.
  - bit_cnt==NB_WORD-1 -> STOP (PARITY if macro defined); otherwise bit_cnt++.
  - Result: each bit is sampled at mid-bit.
- STOP: on a tick with tick_cnt==N_TICK-1:
  - rx_s=1 -> o_data<=shift register, o_rx_done=1 next cycle.
  - rx_s=0 -> o_frame_err=1 next cycle; o_data unchanged; no o_rx_done.
  - Either way -> IDLE.
- Pulses are exactly one i_clk wide, registered, asserted the cycle after the deciding tick. At most one pulse per frame; o_rx_done and error pulses are mutually exclusive.
- Back-to-back frames: re-entry into IDLE is immediate, so a start edge in the same cycle as the stop decision is detected on the next clock. No dead bit-time.
- Break (line held low): repeated frames, each ending in o_frame_err. No lockup.
- o_data is held between frames. It never changes except with o_rx_done.
- Reset mid-frame aborts the frame immediately; no pulse is produced.
- No backpressure: the consumer must accept o_rx_done whenever it occurs. The FIFO drops words when full, and that is the FIFO's concern.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - State PARITY is inserted after DATA; one bit-time; even parity.
  - Sampled bit ≠ XOR(data bits) -> mark the frame.
  - In STOP: a marked frame with stop=1 -> o_parity_err pulse instead of o_rx_done; o_data unchanged.
  - Frame error takes precedence over parity error.
- Undefined:
  - No PARITY state; o_parity_err constant 0.
  - Frame length is 1+NB_WORD+1 bits.

Decomposition:
- Shared header:
  - State encodings IDLE/START/DATA/PARITY/STOP (3-bit localparams).
  - The clog2 function used for counter widths.
- One sub-module: sync_2ff (2-flop synchroniser, async active-low reset to 1); reused by other async inputs.

Test Plan:
- Reset: hold i_rst_n=0 mid-frame, release -> all outputs 0, state IDLE, next clean frame received correctly.
- Byte 0xA5, N_TICK=16, tick every 4 clocks, 8N1 -> single o_rx_done, o_data=0xA5, no error pulses.
- Glitch: i_rx low for 5 ticks then high -> no pulse, still IDLE; following frame 0x3C -> o_data=0x3C.
- Stop bit 0 on byte 0x55 -> o_frame_err one cycle, o_rx_done stays 0, o_data keeps previous 0x3C.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three o_rx_done pulses, o_data 0x00/0xFF/0x81 in order.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> o_rx_done; same byte with parity bit 0 -> o_parity_err, o_data unchanged.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encodings and the counter-width helper for uart_rx.
package uart_rx_pkg;
    localparam logic [2:0] IDLE_ENC   = 3'd0;
    localparam logic [2:0] START_ENC  = 3'd1;
    localparam logic [2:0] DATA_ENC   = 3'd2;
    localparam logic [2:0] PARITY_ENC = 3'd3;
    localparam logic [2:0] STOP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = IDLE_ENC,
        START  = START_ENC,
        DATA   = DATA_ENC,
        PARITY = PARITY_ENC,
        STOP   = STOP_ENC
    } state_t;

    // Never returns 0 so counters stay at least one bit wide.
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input, both flops reset to 1.
// Ports: i_clk clock, i_rst_n async active-low reset, i_d async input, o_q synchronised output.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver assembling LSB-first frames into NB_WORD-bit words.
// Ports: i_clk clock, i_rst_n async active-low reset, i_rx serial line (idle high),
//        i_tick baud oversample strobe (N_TICK per bit), o_data last valid word,
//        o_rx_done new-word pulse, o_frame_err stop-bit-low pulse, o_parity_err parity pulse.
// Option: define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
    parameter int NB_WORD = 8,
    parameter int N_TICK  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx,
    input  logic               i_tick,
    output logic [NB_WORD-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);
    import uart_rx_pkg::*;

    localparam int TW = clog2(N_TICK);
    localparam int BW = clog2(NB_WORD);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t             state, state_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [NB_WORD-1:0] shreg, sh_n, data_n;
    logic               done_n, ferr_n, rx_s;
    wire                half_end = i_tick && tick_cnt == TW'(N_TICK/2 - 1);
    wire                bit_end  = i_tick && tick_cnt == TW'(N_TICK - 1);
`ifdef UART_RX_PARITY_EN
    logic               mark, mark_n, perr_n;
`endif

    sync_2ff u_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_rx), .o_q(rx_s));

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            mark         <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shreg       <= sh_n;
            o_data      <= data_n;
            o_rx_done   <= done_n;
            o_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            mark         <= mark_n;
            o_parity_err <= perr_n;
`endif
        end

`ifndef UART_RX_PARITY_EN
    assign o_parity_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        data_n  = o_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        mark_n  = mark;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE:
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
`ifdef UART_RX_PARITY_EN
                    mark_n  = 1'b0;
`endif
                end
            // Re-check the line at mid start bit to reject glitches.
            START:
                if (half_end) begin
                    state_n = rx_s ? IDLE : DATA;
                    tick_n  = '0;
                    bit_n   = '0;
                end else if (i_tick) tick_n = tick_cnt + TW'(1);
            DATA:
                if (bit_end) begin
                    sh_n    = {rx_s, shreg[NB_WORD-1:1]};
                    tick_n  = '0;
                    state_n = (bit_cnt == BW'(NB_WORD - 1)) ? AFTER_DATA : DATA;
                    bit_n   = bit_cnt + BW'(1);
                end else if (i_tick) tick_n = tick_cnt + TW'(1);
`ifdef UART_RX_PARITY_EN
            PARITY:
                if (bit_end) begin
                    mark_n  = rx_s ^ (^shreg);
                    tick_n  = '0;
                    state_n = STOP;
                end else if (i_tick) tick_n = tick_cnt + TW'(1);
`endif
            STOP:
                if (bit_end) begin
                    tick_n  = '0;
                    state_n = IDLE;
                    if (!rx_s) ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (mark) perr_n = 1'b1;
`endif
                    else begin
                        data_n = shreg;
                        done_n = 1'b1;
                    end
                end else if (i_tick) tick_n = tick_cnt + TW'(1);
            default: state_n = IDLE;
        endcase
    end
endmodule
